ram_bist_ctrl: RTL and testbench

Built-in self-test sequencer that sits directly upstream of the 8x8 synchronous RAM and drives its `w`, `data_adr` and `data_in` pins. It also consumes the RAM's registered `data_out`. On `start` it writes a seeded pattern to every location, reads every location back, compares each read against the expected value, and reports pass/fail, the first failing address and the mismatch count. It shares `clk` with the RAM and does not drive the RAM's `rst`.

---
 rtl/ram_bist_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: march-style self-test sequencer for the 8x8 synchronous RAM.
// Writes a seeded pattern to every location, reads it back with a one-cycle
// pipelined compare, and reports pass, first failing address and miss count.
// Optional build macro: BIST_INV_PASS_EN adds a second, inverted-pattern pass.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; RAM pins parked at zero
// WR     | write expected(a) to a = 0..SIZE-1
// RD     | issue reads a = 0..SIZE-1; compare lags one cycle
// DRAIN  | no new read; finishes the compare of the last address
// DONE   | one-cycle done pulse with results valid
module ram_bist_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADR_W  = 3,
  parameter int SIZE   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              ram_w,
  output logic [ADR_W-1:0]  ram_adr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADR_W-1:0]  fail_adr,
  output logic [ADR_W+1:0]  fail_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_DONE} state_t;

  localparam logic [ADR_W-1:0] LAST    = ADR_W'(SIZE - 1);
  localparam logic [ADR_W+1:0] CNT_MAX = '1;

  function automatic logic [DATA_W-1:0] exp_f(input logic [ADR_W-1:0] a,
                                               input logic [DATA_W-1:0] s,
                                               input logic inv);
    logic [DATA_W-1:0] v;
    v = DATA_W'(a) ^ s;
    return inv ? ~v : v;
  endfunction

  state_t              state_q, state_d;
  logic                ram_w_q, ram_w_d;
  logic [ADR_W-1:0]    ram_adr_q, ram_adr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [ADR_W-1:0]    fail_adr_q, fail_adr_d;
  logic [ADR_W+1:0]    fail_cnt_q, fail_cnt_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [ADR_W-1:0]    cmp_adr_q, cmp_adr_d;
  logic                cmp_vld_q, cmp_vld_d;
`ifdef BIST_INV_PASS_EN
  logic                pidx_q, pidx_d;
`endif

  logic                inv_cur;
  logic                miscmp;
  logic [ADR_W-1:0]    adr_nxt;

  // next-state, RAM drive and result bookkeeping
  always_comb begin
`ifdef BIST_INV_PASS_EN
    inv_cur = pidx_q;
    pidx_d  = pidx_q;
`else
    inv_cur = 1'b0;
`endif
    state_d    = state_q;
    ram_w_d    = ram_w_q;
    ram_adr_d  = ram_adr_q;
    ram_din_d  = ram_din_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    fail_adr_d = fail_adr_q;
    fail_cnt_d = fail_cnt_q;
    seed_d     = seed_q;
    cmp_adr_d  = cmp_adr_q;
    cmp_vld_d  = 1'b0;
    adr_nxt    = ram_adr_q + ADR_W'(1);

    // the read issued last cycle is on ram_dout now
    miscmp = cmp_vld_q && (ram_dout != exp_f(cmp_adr_q, seed_q, inv_cur));
    if (miscmp) begin
      if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
      if (fail_cnt_q == '0)      fail_adr_d = cmp_adr_q;
    end

    case (state_q)
      S_IDLE: begin
        ram_w_d   = 1'b0;
        ram_adr_d = '0;
        ram_din_d = '0;
        busy_d    = 1'b0;
        if (start) begin
          state_d    = S_WR;
          seed_d     = seed;
          fail_cnt_d = '0;
          fail_adr_d = '0;
          pass_d     = 1'b0;
          ram_w_d    = 1'b1;
          ram_adr_d  = '0;
          ram_din_d  = exp_f('0, seed, 1'b0);
          busy_d     = 1'b1;
`ifdef BIST_INV_PASS_EN
          pidx_d     = 1'b0;
`endif
        end
      end
      S_WR: begin
        if (ram_adr_q == LAST) begin
          state_d   = S_RD;
          ram_w_d   = 1'b0;
          ram_adr_d = '0;
          ram_din_d = '0;
        end else begin
          ram_adr_d = adr_nxt;
          ram_din_d = exp_f(adr_nxt, seed_q, inv_cur);
        end
      end
      S_RD: begin
        cmp_adr_d = ram_adr_q;
        cmp_vld_d = 1'b1;
        if (ram_adr_q == LAST) state_d   = S_DRAIN;
        else                   ram_adr_d = adr_nxt;
      end
      S_DRAIN: begin
`ifdef BIST_INV_PASS_EN
        if (!pidx_q) begin
          pidx_d    = 1'b1;
          state_d   = S_WR;
          ram_w_d   = 1'b1;
          ram_adr_d = '0;
          ram_din_d = exp_f('0, seed_q, 1'b1);
        end else begin
          state_d   = S_DONE;
          ram_adr_d = '0;
          done_d    = 1'b1;
          pass_d    = (fail_cnt_d == '0);
        end
`else
        state_d   = S_DONE;
        ram_adr_d = '0;
        done_d    = 1'b1;
        pass_d    = (fail_cnt_d == '0);
`endif
      end
      S_DONE: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        ram_adr_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ram_w_q    <= 1'b0;
      ram_adr_q  <= '0;
      ram_din_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_adr_q <= '0;
      fail_cnt_q <= '0;
      seed_q     <= '0;
      cmp_adr_q  <= '0;
      cmp_vld_q  <= 1'b0;
`ifdef BIST_INV_PASS_EN
      pidx_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ram_w_q    <= ram_w_d;
      ram_adr_q  <= ram_adr_d;
      ram_din_q  <= ram_din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_adr_q <= fail_adr_d;
      fail_cnt_q <= fail_cnt_d;
      seed_q     <= seed_d;
      cmp_adr_q  <= cmp_adr_d;
      cmp_vld_q  <= cmp_vld_d;
`ifdef BIST_INV_PASS_EN
      pidx_q     <= pidx_d;
`endif
    end
  end

  assign ram_w    = ram_w_q;
  assign ram_adr  = ram_adr_q;
  assign ram_din  = ram_din_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail_adr = fail_adr_q;
  assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: directed bench for ram_bist_ctrl with a behavioural 8x8
// RAM that can inject stuck-at bits. Honours BIST_INV_PASS_EN if defined.
module tb_ram_bist_ctrl;

`ifdef BIST_INV_PASS_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif
  localparam int RUN = 17 * NPASS + 1;   // cycle in which done is expected

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] seed;
  logic       ram_w;
  logic [2:0] ram_adr;
  logic [7:0] ram_din, ram_dout;
  logic       busy, done, pass;
  logic [2:0] fail_adr;
  logic [4:0] fail_cnt;

  int n_vec = 0;
  int n_err = 0;

  ram_bist_ctrl #(.DATA_W(8), .ADR_W(3), .SIZE(8)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .ram_w(ram_w), .ram_adr(ram_adr), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy), .done(done), .pass(pass),
    .fail_adr(fail_adr), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  // RAM model: registered read, data_out held while writing, optional fault
  logic [7:0] mem [8];
  logic       fault_en, fault_all;
  logic [2:0] fault_adr;
  logic [7:0] f_or, f_and;
  logic       fault_hit;
  assign fault_hit = fault_en && (fault_all || ram_adr == fault_adr);

  always @(posedge clk) begin
    if (ram_w) mem[ram_adr] <= ram_din;
    else       ram_dout <= fault_hit ? ((mem[ram_adr] | f_or) & f_and) : mem[ram_adr];
  end

  logic [7:0] wr0 [8];
  logic [7:0] wr1 [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_fault(input bit en, input bit all, input logic [2:0] a,
                           input logic [7:0] o, input logic [7:0] n);
    fault_en = en; fault_all = all; fault_adr = a; f_or = o; f_and = n;
  endtask

  // Launches a run from the current negedge (cycle 0) and watches it to idle.
  task automatic run(input logic [7:0] sd, input bit extra_start);
    int done_cyc, done_n, seq_bad, snap_bad, p;
    logic exp_w;
    logic [2:0] exp_adr;
    done_cyc = -1; done_n = 0; seq_bad = 0; snap_bad = 0;
    seed  = sd;
    start = 1'b1;
    for (int k = 1; k <= RUN + 2; k++) begin
      @(negedge clk);
      start = extra_start && (k == 4 || k == 12);
      if (k == 1 && (fail_cnt != 0 || pass || fail_adr != 0)) snap_bad++;
      if (done) begin done_n++; done_cyc = k; end
      if (busy !== (k <= RUN)) seq_bad++;
      if (k < RUN) begin
        p       = (k - 1) % 17;
        exp_w   = (p < 8);
        exp_adr = (p < 8) ? 3'(p) : (p < 16) ? 3'(p - 8) : 3'd7;
        if (ram_w !== exp_w || ram_adr !== exp_adr) seq_bad++;
        if (ram_w) begin
          if ((k - 1) / 17 == 0) wr0[ram_adr] = ram_din;
          else                   wr1[ram_adr] = ram_din;
        end
      end else begin
        if (ram_w !== 1'b0) seq_bad++;
        if (k > RUN && (ram_adr !== 3'd0 || ram_din !== 8'd0)) seq_bad++;
      end
    end
    chk("done_cycle", 32'(done_cyc), 32'(RUN));
    chk("done_pulses", 32'(done_n), 32'd1);
    chk("pin_sequence", 32'(seq_bad), 32'd0);
    chk("clear_on_start", 32'(snap_bad), 32'd0);
  endtask

  task automatic results(input string tag, input bit ep, input int ecnt, input int eadr);
    chk({tag, "_pass"}, 32'(pass), 32'(ep));
    chk({tag, "_cnt"}, 32'(fail_cnt), 32'(ecnt));
    chk({tag, "_adr"}, 32'(fail_adr), 32'(eadr));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin mem[i] = 8'h00; wr0[i] = 8'h00; wr1[i] = 8'h00; end
    ram_dout = 8'h00;
    rst = 1'b1; start = 1'b0; seed = 8'h00;
    set_fault(1'b0, 1'b0, 3'd0, 8'h00, 8'hFF);
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        32'({ram_w, ram_adr, ram_din, busy, done, pass, fail_adr, fail_cnt}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // fault-free, seed 0
    run(8'h00, 1'b0);
    for (int i = 0; i < 8; i++) chk("wr_seed00", 32'(wr0[i]), 32'(i));
`ifdef BIST_INV_PASS_EN
    chk("wr1_seed00_a4", 32'(wr1[4]), 32'hFB);
`endif
    results("clean00", 1'b1, 0, 0);

    // fault-free, seed A5
    @(negedge clk);
    run(8'hA5, 1'b0);
    chk("wr_a5_adr3", 32'(wr0[3]), 32'hA6);
    chk("wr_a5_adr7", 32'(wr0[7]), 32'hA2);
`ifdef BIST_INV_PASS_EN
    chk("wr1_a5_adr3", 32'(wr1[3]), 32'h59);
`endif
    results("cleanA5", 1'b1, 0, 0);

    // bit 1 stuck-at-1 at address 5: visible in the true pass only
    set_fault(1'b1, 1'b0, 3'd5, 8'h02, 8'hFF);
    @(negedge clk);
    run(8'h00, 1'b0);
    results("sa1b1_a5", 1'b0, 1, 5);

    // bit 0 stuck-at-1 at address 5, seed 0: expected(5) already has bit 0 set,
    // so only the inverted pass can see it
    set_fault(1'b1, 1'b0, 3'd5, 8'h01, 8'hFF);
    @(negedge clk);
    run(8'h00, 1'b0);
`ifdef BIST_INV_PASS_EN
    results("sa1b0_a5", 1'b0, 1, 5);
`else
    results("sa1b0_a5", 1'b1, 0, 0);
`endif

    // bit 0 stuck-at-0 at address 2, seed A5: expected(2)=A7, inverted 58
    set_fault(1'b1, 1'b0, 3'd2, 8'h00, 8'hFE);
    @(negedge clk);
    run(8'hA5, 1'b0);
    results("sa0b0_a2", 1'b0, 1, 2);

    // bit 7 stuck-at-0 everywhere, seed A5: every true-pass read misses
    set_fault(1'b1, 1'b1, 3'd0, 8'h00, 8'h7F);
    @(negedge clk);
    run(8'hA5, 1'b0);
    results("sa0b7_all", 1'b0, 8, 0);

    // fault-free with stray start pulses; previous results clear at acceptance
    set_fault(1'b0, 1'b0, 3'd0, 8'h00, 8'hFF);
    @(negedge clk);
    run(8'h3C, 1'b1);
    results("restart", 1'b1, 0, 0);

    // reset in cycle 10 aborts the run
    @(negedge clk);
    seed = 8'h00; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 10) rst = 1'b1;
    end
    @(negedge clk);
    chk("rst_abort",
        32'({ram_w, ram_adr, ram_din, busy, done, pass, fail_adr, fail_cnt}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run(8'h00, 1'b0);
    results("after_rst", 1'b1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
